// File: rtl/vec_popcnt.sv
// ---------------------------------------------------------------------------
// vec_popcnt
//
// Purpose:
//   Pipelined population count for the separated sub-word stream produced by
//   vec_cat. Every vector arrives as two bus words: a full word followed by a
//   zero-padded word. The block counts the ones in each word and sums the two
//   partial counts into one count per vector. Fixed latency, no backpressure.
//
//   Pipeline:
//     input capture : registers the incoming sub-word, ID, valid and last
//     S1            : per-chunk popcounts (BUS_WIDTH/CHUNK_WIDTH chunks)
//     S2            : adder tree over the chunk counts -> word count
//     S3            : FIRST/SECOND pairing FSM, output registers, batch count
//   Second half sampled at edge k -> o_Valid high after edge k+3.
//
// Configuration:
//   VEC_POPCNT_IDCHK_EN - when defined, the second half's ID is compared with
//     the stored first-half ID. A mismatch sets the sticky o_PairErr, produces
//     no output, and the mismatched word becomes the new first half (resync).
//     When undefined, pairing is purely positional, o_PairErr is tied 0 and
//     i_ClrErr is ignored.
//
// Ports:
//   clk         clock, rising edge
//   rstn        synchronous active-low reset
//   i_Vector    separated sub-word (padding bits are 0)
//   i_VecID     ID of the vector the sub-word belongs to
//   i_Valid     sub-word valid, sampled every cycle
//   i_Last      sub-word belongs to the last vector of the batch
//   i_ClrErr    clears o_PairErr (a simultaneous new error wins)
//   o_Count     number of ones in the whole vector
//   o_VecID     ID of the counted vector
//   o_Valid     single-cycle pulse, count valid
//   o_Last      qualifies o_Valid: last vector of the batch
//   o_BatchCnt  vectors emitted in the current batch, including this one
//   o_PairErr   sticky ID-pairing error
//
// Handshake: i_Valid is a plain valid with no ready; every valid sub-word is
// accepted on the edge that samples it. o_Valid is a one-cycle pulse and the
// consumer must take the data in that cycle.
// ---------------------------------------------------------------------------
module vec_popcnt #(
    parameter int BUS_WIDTH    = 512,
    parameter int VEC_ID_WIDTH = 8,
    parameter int CHUNK_WIDTH  = 64,
    parameter int CNT_WIDTH    = $clog2(2*BUS_WIDTH)+1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [BUS_WIDTH-1:0]    i_Vector,
    input  logic [VEC_ID_WIDTH-1:0] i_VecID,
    input  logic                    i_Valid,
    input  logic                    i_Last,
    input  logic                    i_ClrErr,
    output logic [CNT_WIDTH-1:0]    o_Count,
    output logic [VEC_ID_WIDTH-1:0] o_VecID,
    output logic                    o_Valid,
    output logic                    o_Last,
    output logic [VEC_ID_WIDTH-1:0] o_BatchCnt,
    output logic                    o_PairErr
);

    localparam int NCHUNK = BUS_WIDTH / CHUNK_WIDTH;
    localparam int CW1    = $clog2(CHUNK_WIDTH) + 1;  // chunk count width
    localparam int WCW    = $clog2(BUS_WIDTH) + 1;    // word count width

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } state_t;

    function automatic logic [CW1-1:0] f_pop(input logic [CHUNK_WIDTH-1:0] d);
        logic [CW1-1:0] c;
        c = '0;
        for (int b = 0; b < CHUNK_WIDTH; b++) begin
            c = c + CW1'(d[b]);
        end
        return c;
    endfunction

    // ---------------- input capture ----------------
    logic [BUS_WIDTH-1:0]    r_InVec;
    logic [VEC_ID_WIDTH-1:0] r_InID;
    logic                    r_InValid;
    logic                    r_InLast;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_InValid <= 1'b0;
        end else begin
            r_InValid <= i_Valid;
        end
        r_InVec  <= i_Vector;
        r_InID   <= i_VecID;
        r_InLast <= i_Last;
    end

    // ---------------- S1: chunk popcounts ----------------
    logic [CW1-1:0]          w_ChunkCnt [NCHUNK];
    logic [CW1-1:0]          r_S1Cnt    [NCHUNK];
    logic [VEC_ID_WIDTH-1:0] r_S1ID;
    logic                    r_S1Valid;
    logic                    r_S1Last;

    always_comb begin
        for (int c = 0; c < NCHUNK; c++) begin
            w_ChunkCnt[c] = f_pop(r_InVec[c*CHUNK_WIDTH +: CHUNK_WIDTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_S1Valid <= 1'b0;
        end else begin
            r_S1Valid <= r_InValid;
        end
        r_S1Cnt  <= w_ChunkCnt;
        r_S1ID   <= r_InID;
        r_S1Last <= r_InLast;
    end

    // ---------------- S2: word count ----------------
    logic [WCW-1:0]          w_WordSum;
    logic [WCW-1:0]          r_S2Sum;
    logic [VEC_ID_WIDTH-1:0] r_S2ID;
    logic                    r_S2Valid;
    logic                    r_S2Last;

    always_comb begin
        w_WordSum = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            w_WordSum = w_WordSum + WCW'(r_S1Cnt[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_S2Valid <= 1'b0;
        end else begin
            r_S2Valid <= r_S1Valid;
        end
        r_S2Sum  <= w_WordSum;
        r_S2ID   <= r_S1ID;
        r_S2Last <= r_S1Last;
    end

    // ---------------- S3: pairing FSM ----------------
    state_t                  r_State;
    state_t                  w_StateNxt;
    logic [WCW-1:0]          r_Partial;
    logic [WCW-1:0]          w_PartialNxt;
    logic [VEC_ID_WIDTH-1:0] r_PartID;
    logic [VEC_ID_WIDTH-1:0] w_PartIDNxt;
    logic                    w_Emit;
    logic                    w_ErrSet;
    logic [CNT_WIDTH-1:0]    w_Sum;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_State <= FIRST;
        end else begin
            r_State <= w_StateNxt;
        end
    end

    always_comb begin
        w_StateNxt   = r_State;
        w_PartialNxt = r_Partial;
        w_PartIDNxt  = r_PartID;
        w_Emit       = 1'b0;
        w_ErrSet     = 1'b0;
        w_Sum        = CNT_WIDTH'(r_Partial) + CNT_WIDTH'(r_S2Sum);
        case (r_State)
            FIRST: begin
                if (r_S2Valid) begin
                    w_PartialNxt = r_S2Sum;
                    w_PartIDNxt  = r_S2ID;
                    w_StateNxt   = SECOND;
                end
            end
            SECOND: begin
                if (r_S2Valid) begin
`ifdef VEC_POPCNT_IDCHK_EN
                    if (r_S2ID != r_PartID) begin
                        // Resync: treat the stray word as a new first half.
                        w_ErrSet     = 1'b1;
                        w_PartialNxt = r_S2Sum;
                        w_PartIDNxt  = r_S2ID;
                    end else begin
                        w_Emit     = 1'b1;
                        w_StateNxt = FIRST;
                    end
`else
                    w_Emit     = 1'b1;
                    w_StateNxt = FIRST;
`endif
                end
            end
            default: w_StateNxt = FIRST;
        endcase
    end

    // Partial storage carries no reset: it is always rewritten in FIRST
    // before being consumed in SECOND.
    always_ff @(posedge clk) begin
        r_Partial <= w_PartialNxt;
        r_PartID  <= w_PartIDNxt;
    end

    // ---------------- outputs and batch counter ----------------
    logic [CNT_WIDTH-1:0]    r_Count;
    logic [VEC_ID_WIDTH-1:0] r_VecID;
    logic                    r_Valid;
    logic                    r_Last;
    logic [VEC_ID_WIDTH-1:0] r_BatchCnt;
    logic [VEC_ID_WIDTH-1:0] w_BatchBase;
    logic [VEC_ID_WIDTH-1:0] w_BatchNxt;

    // The count shows its final value while the last vector is on the
    // output, and restarts from zero on the following edge.
    always_comb begin
        w_BatchBase = (r_Valid && r_Last) ? '0 : r_BatchCnt;
        w_BatchNxt  = w_Emit ? (w_BatchBase + VEC_ID_WIDTH'(1)) : w_BatchBase;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_Count    <= '0;
            r_VecID    <= '0;
            r_Valid    <= 1'b0;
            r_Last     <= 1'b0;
            r_BatchCnt <= '0;
        end else begin
            r_Valid    <= w_Emit;
            r_Last     <= w_Emit & r_S2Last;
            r_BatchCnt <= w_BatchNxt;
            if (w_Emit) begin
                r_Count <= w_Sum;
                r_VecID <= r_S2ID;
            end
        end
    end

`ifdef VEC_POPCNT_IDCHK_EN
    logic r_PairErr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_PairErr <= 1'b0;
        end else if (w_ErrSet) begin
            r_PairErr <= 1'b1;
        end else if (i_ClrErr) begin
            r_PairErr <= 1'b0;
        end
    end

    assign o_PairErr = r_PairErr;
`else
    // Positional pairing only: the stored ID and the clear input have no use.
    logic w_unused;
    assign w_unused  = ^{i_ClrErr, r_PartID, w_ErrSet};
    assign o_PairErr = 1'b0;
`endif

    assign o_Count    = r_Count;
    assign o_VecID    = r_VecID;
    assign o_Valid    = r_Valid;
    assign o_Last     = r_Last;
    assign o_BatchCnt = r_BatchCnt;

endmodule
